alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Initiator side of the 7-bit ALU interface: accepts commands on a valid/ready port, drives opcode/A/B into the combinational ALU, and captures result/carry/zero.
- Holds an accumulator that supplies operand A and optionally receives the result.
- Returns each completed operation on a valid/ready response port.
- Sits between the control/test harness and the ALU datapath.

Parameters:
- WIDTH, 7, datapath width; must match the ALU result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_opcode  input  4  ALU opcode, 0000..1111
- cmd_imm  input  WIDTH  immediate operand B
- cmd_load  input  1  1: load cmd_imm into the accumulator, no ALU op
- cmd_wb  input  1  1: write the ALU result back to the accumulator
- alu_opcode  output  4  opcode to the ALU
- alu_a  output  WIDTH  operand A to the ALU (accumulator)
- alu_b  output  WIDTH  operand B to the ALU (latched immediate)
- alu_result  input  WIDTH  ALU result
- alu_carry  input  1  ALU carry_out
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_result  output  WIDTH  captured result (or loaded value)
- rsp_carry  output  1  captured carry
- rsp_zero  output  1  captured zero
- acc_out  output  WIDTH  current accumulator value
- op_count  output  CNT_W  completed responses, saturating

Behaviour:
- Single clock domain.
- Reset: synchronous, active-high; all state updates on the rising edge of clk.
  - Values on reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result/carry/zero=0, accumulator=0, alu_opcode=0, alu_b=0, op_count=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch opcode/imm/load/wb.
  - load=1: accumulator<=imm; rsp_result<=imm, rsp_carry<=0, rsp_zero<=(imm==0); go to RESP.
  - load=0: go to EXEC.
- EXEC (exactly one cycle):
  - cmd_ready=0.
  - alu_opcode, alu_a (accumulator) and alu_b are driven from registers, so the ALU sees stable inputs for the whole cycle.
  - At the cycle end, capture alu_result/alu_carry/alu_zero into the rsp_* registers.
  - If wb=1, accumulator<=alu_result.
  - Go to RESP.
- RESP:
  - rsp_valid=1, cmd_ready=0.
  - rsp_* are held stable until the handshake.
  - On rsp_ready: rsp_valid<=0, op_count increments (saturating at all-ones), go to IDLE.
- Latency:
  - ALU command: accepted at edge N; rsp_valid high from N+2.
  - Load command: rsp_valid high from N+1.
- Throughput: max one ALU command per 3 cycles with rsp_ready held at 1.
- No command pipelining; cmd_ready is low whenever the FSM is not in IDLE.
- alu_a always equals acc_out; alu_opcode/alu_b hold their last values outside EXEC.
- Width rules:
  - The accumulator receives exactly WIDTH bits.
  - Carry is meaningful only for opcodes 0000 and 1000; for other opcodes it is passed through as the ALU drives it (0).
- Divide-by-zero protection is the ALU's responsibility; the sequencer passes B unmodified.
- Reset mid-operation (EXEC or RESP): the pending response is discarded, the accumulator is cleared, and op_count is not incremented.
- cmd_valid while not ready: ignored; command inputs are not sampled.
- rsp_ready high while rsp_valid=0: no effect.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_XOR=0100, OP_NAND=0101, OP_NOR=0110, OP_XNOR=0111, OP_SHL=1000, OP_SHR=1001, OP_ROL=1010, OP_ROR=1011, OP_ASL=1100, OP_ASR=1101, OP_MUL=1110, OP_DIV=1111.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One natural sub-module: sat_counter (CNT_W-wide saturating increment), used for op_count.
- The ALU itself is instantiated alongside this block in the testbench and top level, not inside it.

Test Plan:
- Load then add: load imm=5 (wb n/a); ADD imm=3, wb=1 -> rsp_result=8, carry=0, zero=0, acc_out=8, rsp_valid 2 cycles after accept.
- Overflow: load 127; ADD imm=1, wb=1 -> rsp_result=0, carry=1, zero=1, acc_out=0.
- No write-back: load 9; SUB imm=9, wb=0 -> rsp_result=0, zero=1; acc_out stays 9.
- Backpressure: rsp_ready held low 4 cycles after rsp_valid -> rsp_* stable, cmd_ready=0, a new cmd_valid is ignored; rsp_ready=1 -> next cycle IDLE, op_count increments by 1.
- Reset mid-EXEC: assert rst during EXEC of MUL imm=3 -> next cycle state IDLE, rsp_valid=0, acc_out=0, op_count=0.
- Counter saturation: with CNT_W=2, complete 5 commands -> op_count=3.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcodes and FSM encoding for the ALU command sequencer.
package alu_cmd_sequencer_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_NOR  = 4'b0110;
   localparam logic [3:0] OP_XNOR = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_ROL  = 4'b1010;
   localparam logic [3:0] OP_ROR  = 4'b1011;
   localparam logic [3:0] OP_ASL  = 4'b1100;
   localparam logic [3:0] OP_ASR  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;
   localparam logic [3:0] OP_DIV  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational ALU from an accumulator and a command port,
// returning each result on a valid/ready response port.
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_imm,
   input  logic             cmd_load,
   input  logic             cmd_wb,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] acc_out,
   output logic [CNT_W-1:0] op_count
);

   state_t           state;
   state_t           state_nx;
   logic [3:0]       opc_q;
   logic [WIDTH-1:0] imm_q;
   logic             wb_q;
   logic [WIDTH-1:0] acc;
   logic             rsp_fire;

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nx = cmd_load ? RESP : EXEC;
            end
         end
         EXEC: state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         opc_q      <= '0;
         imm_q      <= '0;
         wb_q       <= 1'b0;
         acc        <= '0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == IDLE) && cmd_valid) begin
            opc_q <= cmd_opcode;
            imm_q <= cmd_imm;
            wb_q  <= cmd_wb;
            // Loads bypass the ALU and answer straight away.
            if (cmd_load) begin
               acc        <= cmd_imm;
               rsp_result <= cmd_imm;
               rsp_carry  <= 1'b0;
               rsp_zero   <= (cmd_imm == '0);
            end
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            if (wb_q) begin
               acc <= alu_result;
            end
         end
      end
   end

   assign rsp_fire   = rsp_valid & rsp_ready;
   assign alu_opcode = opc_q;
   assign alu_a      = acc;
   assign alu_b      = imm_q;
   assign acc_out    = acc;

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (rsp_fire),
      .cnt (op_count)
   );

endmodule
